// File: rtl/rpc_ctrl_pkg.sv
// Shared types and helpers for the RPC DRAM controller command path.
// arb_cmd_t carries the widest supported payload; users keep the low bits
// that match their own address/length parameters.
// The optional RPC_ARB_AGE_EN build of rpc_cmd_arbiter needs nothing extra here.
package rpc_ctrl_pkg;

  localparam int ARB_MAX_CH   = 16;
  localparam int ARB_ADDR_MAX = 32;
  localparam int ARB_LEN_MAX  = 16;

  typedef struct packed {
    logic                    write;
    logic [ARB_ADDR_MAX-1:0] addr;
    logic [ARB_LEN_MAX-1:0]  len;
  } arb_cmd_t;

  // Round-robin pick: scan from ptr upward (wrapping at num_ch) and return a
  // one-hot vector marking the first valid channel, or zero if none is valid.
  function automatic logic [ARB_MAX_CH-1:0] rr_pick(
    input logic [ARB_MAX_CH-1:0] valid,
    input int unsigned           ptr,
    input int unsigned           num_ch
  );
    logic [ARB_MAX_CH-1:0] grant;
    logic                  found;
    int unsigned           idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < ARB_MAX_CH; i++) begin
      if (i < num_ch) begin
        idx = ptr + i;
        if (idx >= num_ch) idx = idx - num_ch;
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rpc_id_fifo.sv
// In-flight channel-ID FIFO. Records the issuing channel of every granted
// command so completions, which return in command order, can be routed back.
// Depth must be a power of two so the pointers wrap naturally.
module rpc_id_fifo
  import rpc_ctrl_pkg::*;
#(
  parameter int Width = 2,
  parameter int Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rpc_cmd_arbiter.sv
// Round-robin command arbiter merging NumCh channels onto the single RPC DRAM
// controller command port, with in-order completion routing back to channels.
// Optional build macro RPC_ARB_AGE_EN: per-channel wait counters; any channel
// that has waited AgeLimit cycles wins over round-robin (lowest index first).
//
// Handshake: a channel command transfers when ch_valid_i[k] && ch_ready_o[k];
// the controller command transfers when cmd_valid_o && cmd_ready_i. Payload is
// held stable while cmd_valid_o && !cmd_ready_i.
module rpc_cmd_arbiter
  import rpc_ctrl_pkg::*;
#(
  parameter int NumCh          = 4,
  parameter int DramAddrWidth  = 20,
  parameter int DramLenWidth   = 6,
  parameter int MaxOutstanding = 4,
  parameter int AgeLimit       = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumCh-1:0]                  ch_valid_i,
  output logic [NumCh-1:0]                  ch_ready_o,
  input  logic [NumCh-1:0]                  ch_write_i,
  input  logic [NumCh*DramAddrWidth-1:0]    ch_addr_i,
  input  logic [NumCh*DramLenWidth-1:0]     ch_len_i,
  output logic [NumCh-1:0]                  ch_done_o,
  output logic                              cmd_valid_o,
  input  logic                              cmd_ready_i,
  output logic                              cmd_write_o,
  output logic [DramAddrWidth-1:0]          cmd_addr_o,
  output logic [DramLenWidth-1:0]           cmd_len_o,
  output logic [$clog2(NumCh)-1:0]          cmd_ch_o,
  input  logic                              done_i,
  output logic                              err_o
);

  localparam int ChW  = $clog2(NumCh);
  localparam int CntW = $clog2(MaxOutstanding) + 1;

  // Elaboration-time parameter sanity checks.
  if (NumCh < 2 || NumCh > ARB_MAX_CH) begin : g_bad_numch
    $error("rpc_cmd_arbiter: NumCh out of range");
  end
  if (MaxOutstanding < 2 || (MaxOutstanding & (MaxOutstanding - 1)) != 0) begin : g_bad_depth
    $error("rpc_cmd_arbiter: MaxOutstanding must be a power of two >= 2");
  end
  if (DramAddrWidth > ARB_ADDR_MAX || DramLenWidth > ARB_LEN_MAX) begin : g_bad_width
    $error("rpc_cmd_arbiter: payload wider than arb_cmd_t");
  end
  if (AgeLimit < 1) begin : g_bad_age
    $error("rpc_cmd_arbiter: AgeLimit must be >= 1");
  end

  logic [ChW-1:0]        rr_q;
  logic [ARB_MAX_CH-1:0] valid_ext;
  logic [ARB_MAX_CH-1:0] rr_oh_ext;
  logic [NumCh-1:0]      sel_oh;
  logic [NumCh-1:0]      grant_oh;
  logic                  grant_any;
  logic [ChW-1:0]        grant_idx;
  logic                  can_accept;
  arb_cmd_t              sel_cmd;
  arb_cmd_t              cmd_q;
  logic                  cmd_valid_q;
  logic [ChW-1:0]        cmd_ch_q;
  logic [NumCh-1:0]      ch_done_q;
  logic                  err_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ChW-1:0]        fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CntW-1:0]       fifo_count;

  // Upper bits of the wide helper results are structurally zero.
  logic unused_wide;
  assign unused_wide = ^rr_oh_ext ^ ^cmd_q;

  // The output stage is counted as outstanding, and a pop in this cycle does
  // not open a slot until the next cycle.
  assign can_accept = (!cmd_valid_q || cmd_ready_i) &&
                      (fifo_count < CntW'(MaxOutstanding));

  // Widen the request vector for the package round-robin helper.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NumCh-1:0]   = ch_valid_i;
  end

  assign rr_oh_ext = rr_pick(valid_ext, 32'(rr_q), 32'(NumCh));

`ifdef RPC_ARB_AGE_EN
  localparam int AgeW = $clog2(AgeLimit + 1);

  logic [AgeW-1:0]  age_q [NumCh];
  logic [NumCh-1:0] aged;

  // A channel is aged once its wait counter has saturated while still requesting.
  always_comb begin
    for (int k = 0; k < NumCh; k++) begin
      aged[k] = ch_valid_i[k] && (age_q[k] == AgeW'(AgeLimit));
    end
  end

  // Wait counters: count up while requesting and not granted, clear otherwise.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumCh; k++) begin
      if (rst_i || !ch_valid_i[k] || grant_oh[k]) begin
        age_q[k] <= '0;
      end else if (age_q[k] != AgeW'(AgeLimit)) begin
        age_q[k] <= age_q[k] + AgeW'(1);
      end
    end
  end

  // Aged channels override round-robin; lowest aged index wins.
  always_comb begin
    sel_oh = rr_oh_ext[NumCh-1:0];
    if (|aged) sel_oh = aged & (-aged);
  end
`else
  // Pure round-robin selection.
  always_comb begin
    sel_oh = rr_oh_ext[NumCh-1:0];
  end
`endif

  // Gate the selection with the accept condition and encode the winner.
  always_comb begin
    grant_oh  = can_accept ? sel_oh : '0;
    grant_any = |grant_oh;
    grant_idx = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (grant_oh[k]) grant_idx = ChW'(k);
    end
  end

  assign ch_ready_o = grant_oh;

  // Mux the winning channel's payload into the command struct.
  always_comb begin
    sel_cmd                        = '0;
    sel_cmd.write                  = ch_write_i[grant_idx];
    sel_cmd.addr[DramAddrWidth-1:0] = ch_addr_i[grant_idx*DramAddrWidth +: DramAddrWidth];
    sel_cmd.len[DramLenWidth-1:0]   = ch_len_i[grant_idx*DramLenWidth +: DramLenWidth];
  end

  // Output stage: load on grant, clear after a handshake with no refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_ch_q    <= '0;
    end else if (grant_any) begin
      cmd_valid_q <= 1'b1;
      cmd_q       <= sel_cmd;
      cmd_ch_q    <= grant_idx;
    end else if (cmd_ready_i) begin
      cmd_valid_q <= 1'b0;
    end
  end

  // Round-robin pointer moves to the channel after the one just granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (grant_any) begin
      rr_q <= (grant_idx == ChW'(NumCh - 1)) ? '0 : grant_idx + ChW'(1);
    end
  end

  assign fifo_push = grant_any && !fifo_full;
  assign fifo_pop  = done_i && !fifo_empty;

  rpc_id_fifo #(
    .Width (ChW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (grant_idx),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Completion routing pulse and sticky error for a completion with nothing in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_done_q <= '0;
      err_q     <= 1'b0;
    end else begin
      ch_done_q <= '0;
      if (fifo_pop) ch_done_q[fifo_head] <= 1'b1;
      if (done_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_write_o = cmd_q.write;
  assign cmd_addr_o  = cmd_q.addr[DramAddrWidth-1:0];
  assign cmd_len_o   = cmd_q.len[DramLenWidth-1:0];
  assign cmd_ch_o    = cmd_ch_q;
  assign ch_done_o   = ch_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Directed bench for rpc_cmd_arbiter (default parameters, 4 channels).
module tb_rpc_cmd_arbiter;

  localparam int NumCh = 4;
  localparam int AW    = 20;
  localparam int LW    = 6;

  logic                  clk;
  logic                  rst;
  logic [NumCh-1:0]      ch_valid;
  logic [NumCh-1:0]      ch_ready;
  logic [NumCh-1:0]      ch_write;
  logic [NumCh*AW-1:0]   ch_addr;
  logic [NumCh*LW-1:0]   ch_len;
  logic [NumCh-1:0]      ch_done;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [AW-1:0]         cmd_addr;
  logic [LW-1:0]         cmd_len;
  logic [1:0]            cmd_ch;
  logic                  done;
  logic                  err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  rpc_cmd_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ch_valid_i  (ch_valid),
    .ch_ready_o  (ch_ready),
    .ch_write_i  (ch_write),
    .ch_addr_i   (ch_addr),
    .ch_len_i    (ch_len),
    .ch_done_o   (ch_done),
    .cmd_valid_o (cmd_valid),
    .cmd_ready_i (cmd_ready),
    .cmd_write_o (cmd_write),
    .cmd_addr_o  (cmd_addr),
    .cmd_len_o   (cmd_len),
    .cmd_ch_o    (cmd_ch),
    .done_i      (done),
    .err_o       (err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
    ch_addr[k*AW +: AW] = a;
    ch_len[k*LW +: LW]  = l;
    ch_write[k]         = w;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ch_valid  = '0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ch_valid  = '0;
    ch_write  = '0;
    ch_addr   = '0;
    ch_len    = '0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_ch_ready",  32'(ch_ready),  32'd0);
    check("rst_ch_done",   32'(ch_done),   32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_cmd_ch",    32'(cmd_ch),    32'd0);

    // Single channel
    set_ch(1, 20'h00123, 6'd8, 1'b1);
    ch_valid  = 4'b0010;
    cmd_ready = 1'b1;
    settle();
    check("single_ready", 32'(ch_ready), 32'b0010);
    tick();
    ch_valid = '0;
    check("single_valid", 32'(cmd_valid), 32'd1);
    check("single_ch",    32'(cmd_ch),    32'd1);
    check("single_addr",  32'(cmd_addr),  32'h00123);
    check("single_len",   32'(cmd_len),   32'd8);
    check("single_write", 32'(cmd_write), 32'd1);
    tick();
    check("single_drain", 32'(cmd_valid), 32'd0);
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("single_done", 32'(ch_done), 32'b0010);
    tick();
    check("single_done_1cyc", 32'(ch_done), 32'd0);
    check("single_err", 32'(err), 32'd0);

    // Round-robin fairness with done every cycle after the first grant
    do_reset();
    for (int k = 0; k < NumCh; k++) set_ch(k, 20'h01000 + 20'(k), 6'(k + 1), k[0]);
    ch_valid  = 4'b1111;
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      done = (i > 0);
      exp_q.push_back(2'(i % 4));
      settle();
      check("rr_ready", 32'(ch_ready), 32'(1) << (i % 4));
      tick();
      check("rr_ch",   32'(cmd_ch),   32'(exp_q.pop_front()));
      check("rr_addr", 32'(cmd_addr), 32'h01000 + 32'(i % 4));
      if (i > 0) check("rr_done", 32'(ch_done), 32'(1) << ((i - 1) % 4));
    end
    ch_valid = '0;
    done     = 1'b1;
    tick();
    done = 1'b0;
    check("rr_done_last", 32'(ch_done), 32'b0010);
    check("rr_err", 32'(err), 32'd0);

    // Backpressure: held command stays stable, no grants
    do_reset();
    set_ch(0, 20'h0ABCD, 6'd17, 1'b0);
    set_ch(1, 20'h05555, 6'd3, 1'b1);
    ch_valid  = 4'b0001;
    cmd_ready = 1'b0;
    settle();
    check("bp_first_ready", 32'(ch_ready), 32'b0001);
    tick();
    ch_valid = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_ready", 32'(ch_ready),  32'd0);
      check("bp_valid", 32'(cmd_valid), 32'd1);
      check("bp_addr",  32'(cmd_addr),  32'h0ABCD);
      check("bp_len",   32'(cmd_len),   32'd17);
      check("bp_ch",    32'(cmd_ch),    32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    settle();
    check("bp_release_ready", 32'(ch_ready), 32'b0010);
    tick();
    ch_valid = '0;
    check("bp_release_ch", 32'(cmd_ch), 32'd1);

    // Full FIFO: four grants without completions
    do_reset();
    ch_valid  = 4'b1111;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_fill_ch", 32'(cmd_ch), 32'(i));
    end
    settle();
    check("full_ready",     32'(ch_ready),  32'd0);
    check("full_cmd_valid", 32'(cmd_valid), 32'd1);
    done = 1'b1;
    settle();
    check("full_pop_same_cycle", 32'(ch_ready), 32'd0);
    tick();
    done = 1'b0;
    settle();
    check("full_pop_done",  32'(ch_done),   32'b0001);
    check("full_drained",   32'(cmd_valid), 32'd0);
    check("full_next_ready", 32'(ch_ready), 32'b0001);
    tick();
    check("full_next_valid", 32'(cmd_valid), 32'd1);
    check("full_next_ch",    32'(cmd_ch),    32'd0);

    // Completion routing 2,0,3 then a spurious done
    do_reset();
    cmd_ready = 1'b1;
    ch_valid  = 4'b0100;
    tick();
    check("route_grant0", 32'(cmd_ch), 32'd2);
    ch_valid = 4'b0001;
    tick();
    check("route_grant1", 32'(cmd_ch), 32'd0);
    ch_valid = 4'b1000;
    tick();
    check("route_grant2", 32'(cmd_ch), 32'd3);
    ch_valid = '0;
    done     = 1'b1;
    tick();
    check("route_done0", 32'(ch_done), 32'b0100);
    tick();
    check("route_done1", 32'(ch_done), 32'b0001);
    tick();
    check("route_done2", 32'(ch_done), 32'b1000);
    done = 1'b0;
    tick();
    check("route_idle_done", 32'(ch_done), 32'd0);
    check("route_no_err",    32'(err),     32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("route_err_set",  32'(err),     32'd1);
    check("route_err_done", 32'(ch_done), 32'd0);
    repeat (3) tick();
    check("route_err_sticky", 32'(err), 32'd1);

    // Reset mid-operation: 3 outstanding, one held, error set
    cmd_ready = 1'b1;
    ch_valid  = 4'b0111;
    tick();
    tick();
    tick();
    check("mid_held_ch", 32'(cmd_ch), 32'd2);
    ch_valid  = '0;
    cmd_ready = 1'b0;
    done      = 1'b1;
    rst       = 1'b1;
    tick();
    rst  = 1'b0;
    done = 1'b0;
    check("mid_cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid_ch_done",   32'(ch_done),   32'd0);
    check("mid_err",       32'(err),       32'd0);
    ch_valid  = 4'b1111;
    cmd_ready = 1'b1;
    settle();
    check("mid_next_ready", 32'(ch_ready), 32'b0001);
    tick();
    ch_valid = '0;
    check("mid_next_ch", 32'(cmd_ch), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("mid_fifo_cleared", 32'(ch_done), 32'b0001);
    check("mid_err_after",    32'(err),     32'd0);

`ifdef RPC_ARB_AGE_EN
    // Aging: ch3 waits behind a held command, then beats round-robin's ch0
    do_reset();
    ch_valid  = 4'b1000;
    cmd_ready = 1'b0;
    settle();
    check("age_first_ready", 32'(ch_ready), 32'b1000);
    tick();
    repeat (20) tick();
    ch_valid  = 4'b1001;
    cmd_ready = 1'b1;
    settle();
    check("age_override", 32'(ch_ready), 32'b1000);
    tick();
    ch_valid = '0;
    check("age_grant_ch", 32'(cmd_ch), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rpc_cmd_arbiter.md
Name: rpc_cmd_arbiter

Overview:
- Multi-channel command arbiter in front of the RPC DRAM controller command path.
- Merges NumCh independent read/write command streams into the single controller command port using round-robin arbitration.
- Tracks outstanding commands in grant order and routes each controller completion back to the issuing channel.
- Lets several AXI front-ends or DMA ports share one RPC DRAM device.

Parameters:
- NumCh, 4, number of upstream command channels (>=2).
- DramAddrWidth, 20, command address width.
- DramLenWidth, 6, command burst length width.
- MaxOutstanding, 4, depth of in-flight channel-ID FIFO (power of 2, >=2).
- AgeLimit, 16, wait cycles before a channel is promoted (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- ch_valid_i  in  NumCh  per-channel command valid.
- ch_ready_o  out  NumCh  per-channel command accept.
- ch_write_i  in  NumCh  1=write, 0=read.
- ch_addr_i  in  NumCh*DramAddrWidth  packed addresses; channel k in slice k.
- ch_len_i  in  NumCh*DramLenWidth  packed burst lengths.
- ch_done_o  out  NumCh  one-cycle completion pulse to the issuing channel.
- cmd_valid_o  out  1  command to controller valid.
- cmd_ready_i  in  1  controller accepts command.
- cmd_write_o  out  1  selected write flag.
- cmd_addr_o  out  DramAddrWidth  selected address.
- cmd_len_o  out  DramLenWidth  selected length.
- cmd_ch_o  out  $clog2(NumCh)  channel ID of the presented command.
- done_i  in  1  controller completion pulse; completions occur in command order.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_i high at a clock edge): all outputs 0; rr pointer=0; ID FIFO empty (count=0); err_o cleared; any held command dropped.
- Output stage: a single register holds the presented command. cmd_* payload stays stable while cmd_valid_o=1 && cmd_ready_i=0.
- Accept condition: can_accept = (!cmd_valid_o || cmd_ready_i) && (count < MaxOutstanding).
  - A pop in the same cycle does NOT free a slot.
  - count includes the entry in the output stage.
- Arbitration (combinational, only while can_accept):
  - Start at index rr and pick the first channel with ch_valid_i=1.
  - Raise exactly one ch_ready_o bit; no other bit may be high.
  - No requester: ch_ready_o=0, rr unchanged.
- Grant of channel k:
  - Output register loads k's payload; cmd_valid_o=1 next cycle (latency 1).
  - k is pushed into the ID FIFO.
  - rr <= (k+1) mod NumCh, wrapping NumCh-1 to 0.
- Handshake cmd_valid_o && cmd_ready_i with no new grant: cmd_valid_o <= 0 next cycle.
- Back-to-back: with grant and drain in the same cycle, a new command can follow every cycle.
- Completion: done_i pops the FIFO head h; ch_done_o[h] pulses for exactly one cycle on the next cycle.
  - Push and pop in the same cycle: count unchanged, both take effect.
- done_i with FIFO empty: ignored, err_o <= 1 (sticky until reset).
- Full FIFO (count=MaxOutstanding): all ch_ready_o=0 and the output register holds its command. The controller is still free to take the held command.
- ch_valid_i deasserted before grant: allowed, nothing issued. Payload must be stable while valid.

Optional Feature:
- Macro: RPC_ARB_AGE_EN.
- Defined:
  - Per-channel wait counter, saturating at AgeLimit.
  - Increments each cycle the channel is valid and not granted; clears on grant or when valid drops.
  - Any channel at AgeLimit wins over round-robin; lowest index wins if several are aged.
  - rr still updates to granted+1.
- Undefined: pure round-robin, no counters synthesised.

Decomposition:
- rpc_ctrl_pkg gains:
  - arb_cmd_t struct {write, addr, len}.
  - function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module: rpc_id_fifo (width $clog2(NumCh), depth MaxOutstanding; push/pop/full/empty/count). Used for in-order completion routing.

Test Plan:
- Single channel: ch_valid_i=4'b0010, addr 0x00123, len 8, write; cmd_ready_i=1.
  - Expect cmd_valid_o next cycle, cmd_ch_o=1, addr 0x00123.
  - done_i 5 cycles later -> ch_done_o=4'b0010 for one cycle.
- Round-robin fairness: all 4 channels valid, ready always high, done_i each cycle.
  - Grant order 0,1,2,3,0,1; cmd_ch_o matches; no channel granted twice within 4 grants.
- Backpressure: cmd_ready_i=0 for 10 cycles with a command held.
  - cmd_addr_o, cmd_len_o, cmd_ch_o constant; all ch_ready_o=0.
- Full FIFO: 4 grants with no done_i.
  - ch_ready_o=0 even with cmd_ready_i=1.
  - done_i in the same cycle as a pending request: no grant that cycle, grant the following cycle.
- Completion routing: grants to ch 2,0,3 then three done_i pulses -> ch_done_o pulses 4'b0100, 4'b0001, 4'b1000.
  - Extra done_i -> err_o=1 and stays set.
- Reset mid-operation: rst_i high with 3 outstanding and a held command.
  - Next cycle cmd_valid_o=0, ch_done_o=0, err_o=0, next grant from channel 0.
  - With RPC_ARB_AGE_EN: ch3 starved 16 cycles by ch0/1 traffic -> ch3 granted next.
